ipsxe_floating_point_mul_norm_round_v1_0: RTL

//  Downstream of the double-precision mantissa multiplier. Takes its raw {sign, exp-sum, 2*(MAN_WIDTH+1)-bit product},

---
 rtl/ipsxe_floating_point_mul_norm_round_v1_0.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ipsxe_floating_point_mul_norm_round_v1_0.sv
// Normalise, round-to-nearest-even and pack stage behind the double-precision mantissa multiplier.
// Three clock-enabled register stages: normalise -> round -> range/special/pack.
module ipsxe_floating_point_mul_norm_round_v1_0 #(
   parameter int EXP_WIDTH = 11,
   parameter int MAN_WIDTH = 52
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst_n,
   input  logic                                   i_aclken,
   input  logic                                   i_valid,
   input  logic [2*(MAN_WIDTH+1)+EXP_WIDTH+1:0]   i_a_mul_b,
   input  logic [1:0]                             i_special,
   output logic                                   o_valid,
   output logic [EXP_WIDTH+MAN_WIDTH:0]           o_result,
   output logic                                   o_overflow,
   output logic                                   o_underflow
);

   localparam int P    = 2*MAN_WIDTH + 2;
   localparam int EW   = EXP_WIDTH + 3;
   localparam int BIAS = (1 << (EXP_WIDTH-1)) - 1;
   localparam int EMAX = (1 << EXP_WIDTH) - 1;

   localparam logic signed [EW-1:0] BIAS_E = BIAS[EW-1:0];
   localparam logic signed [EW-1:0] EMAX_E = EMAX[EW-1:0];
   localparam logic signed [EW-1:0] ONE_E  = {{(EW-1){1'b0}}, 1'b1};

   localparam logic [1:0] SP_NORMAL = 2'b00;
   localparam logic [1:0] SP_ZERO   = 2'b01;
   localparam logic [1:0] SP_INF    = 2'b10;

   // ---------------------------------------------------------------
   // input field split
   // ---------------------------------------------------------------
   logic                 in_sign;
   logic [EXP_WIDTH:0]   in_exp_sum;
   logic [P-1:0]         in_prod;

   assign in_sign    = i_a_mul_b[P+EXP_WIDTH+1];
   assign in_exp_sum = i_a_mul_b[P+EXP_WIDTH:P];
   assign in_prod    = i_a_mul_b[P-1:0];

   // ---------------------------------------------------------------
   // stage 1 : normalise
   // ---------------------------------------------------------------
   logic                   n_top;
   logic [MAN_WIDTH-1:0]   n_man;
   logic                   n_guard;
   logic                   n_sticky;
   logic signed [EW-1:0]   n_exp;

   always_comb begin
      n_top = in_prod[P-1];
      if (n_top) begin
         n_man    = in_prod[P-2 -: MAN_WIDTH];
         n_guard  = in_prod[P-2-MAN_WIDTH];
         n_sticky = |in_prod[P-3-MAN_WIDTH:0];
         n_exp    = $signed({2'b00, in_exp_sum}) - BIAS_E + ONE_E;
      end else begin
         n_man    = in_prod[P-3 -: MAN_WIDTH];
         n_guard  = in_prod[P-3-MAN_WIDTH];
         n_sticky = |in_prod[P-4-MAN_WIDTH:0];
         n_exp    = $signed({2'b00, in_exp_sum}) - BIAS_E;
      end
   end

   logic                   s1_valid;
   logic                   s1_sign;
   logic [1:0]             s1_special;
   logic signed [EW-1:0]   s1_exp;
   logic [MAN_WIDTH-1:0]   s1_man;
   logic                   s1_guard;
   logic                   s1_sticky;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid   <= 1'b0;
         s1_sign    <= 1'b0;
         s1_special <= 2'b00;
         s1_exp     <= '0;
         s1_man     <= '0;
         s1_guard   <= 1'b0;
         s1_sticky  <= 1'b0;
      end else if (i_aclken) begin
         s1_valid   <= i_valid;
         s1_sign    <= in_sign;
         s1_special <= i_special;
         s1_exp     <= n_exp;
         s1_man     <= n_man;
         s1_guard   <= n_guard;
         s1_sticky  <= n_sticky;
      end
   end

   // ---------------------------------------------------------------
   // stage 2 : round to nearest, ties to even
   // ---------------------------------------------------------------
   logic                 r_inc;
   logic [MAN_WIDTH:0]   r_sum;

   assign r_inc = s1_guard & (s1_sticky | s1_man[0]);
   assign r_sum = {1'b0, s1_man} + {{MAN_WIDTH{1'b0}}, r_inc};

   logic                   s2_valid;
   logic                   s2_sign;
   logic [1:0]             s2_special;
   logic signed [EW-1:0]   s2_exp;
   logic [MAN_WIDTH-1:0]   s2_man;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s2_valid   <= 1'b0;
         s2_sign    <= 1'b0;
         s2_special <= 2'b00;
         s2_exp     <= '0;
         s2_man     <= '0;
      end else if (i_aclken) begin
         s2_valid   <= s1_valid;
         s2_sign    <= s1_sign;
         s2_special <= s1_special;
         // mantissa wrapped to 1.0 * 2: fraction is zero, bump exponent
         if (r_sum[MAN_WIDTH]) begin
            s2_man <= '0;
            s2_exp <= s1_exp + ONE_E;
         end else begin
            s2_man <= r_sum[MAN_WIDTH-1:0];
            s2_exp <= s1_exp;
         end
      end
   end

   // ---------------------------------------------------------------
   // stage 3 : specials, range check, pack
   // ---------------------------------------------------------------
   logic exp_ovf;
   logic exp_unf;

   assign exp_ovf = (s2_exp >= EMAX_E);
   assign exp_unf = s2_exp[EW-1] | (s2_exp == '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid     <= 1'b0;
         o_result    <= '0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else if (i_aclken) begin
         o_valid     <= s2_valid;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
         if (s2_special == SP_NORMAL) begin
            if (exp_ovf) begin
               o_result   <= {s2_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
               o_overflow <= 1'b1;
            end else if (exp_unf) begin
               o_result    <= {s2_sign, {EXP_WIDTH{1'b0}}, {MAN_WIDTH{1'b0}}};
               o_underflow <= 1'b1;
            end else begin
               o_result <= {s2_sign, s2_exp[EXP_WIDTH-1:0], s2_man};
            end
         end else if (s2_special == SP_ZERO) begin
            o_result <= {s2_sign, {EXP_WIDTH{1'b0}}, {MAN_WIDTH{1'b0}}};
         end else if (s2_special == SP_INF) begin
            o_result <= {s2_sign, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
         end else begin
            // NaN is always emitted as the positive canonical quiet NaN
            o_result <= {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
         end
      end
   end

endmodule
